// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 9;
    localparam int FETCH_DATA_W = 32;
    localparam int DATA_BYTES   = FETCH_DATA_W / 8;

    typedef logic [FETCH_ADDR_W-1:0] pc_t;
    typedef logic [FETCH_DATA_W-1:0] insn_t;

    typedef struct packed {
        pc_t   pc;
        insn_t insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shift-register FIFO of {pc, insn}; slot0 is always the head.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: caller never pushes when full or pops when empty; flush empties it.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slot0;
    fetch_entry_t slot1;

    // Shift-register storage: when the FIFO drains, slot0 keeps the last popped
    // entry, so the head holds its last value while count is 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= push_dat;
                    end else begin
                        slot1 <= push_dat;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        slot0 <= slot1;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= push_dat;
                    end else begin
                        slot0 <= push_dat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head = slot0;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC sequencer: issues reads to a registered-read memory, buffers words for decode.
// Latency: address issued in cycle c shows on out_valid in cycle c+2; 1 insn/cycle sustained.
// Backpressure: issue stops once buffered + in-flight words reach 2; redirect flushes everything.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = FETCH_ADDR_W,
    parameter int                    DATA_WIDTH = FETCH_DATA_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_insn
);

    // Internal types come from fetch_pkg; the width parameters must match it.
    pc_t          pc;
    pc_t          inflight_pc;
    pc_t          issue_pc;
    logic         inflight;
    logic         issue;
    logic         pop;
    logic         push;
    logic [1:0]   fifo_count;
    logic [2:0]   occupancy;
    fetch_entry_t push_dat;
    fetch_entry_t head;

    // A redirect overrides the sequential PC and always issues, since it
    // discards every older word and so frees all space.
    assign issue_pc  = redirect_valid ? redirect_pc : pc;
    assign mem_addr  = issue_pc;

    // Output is suppressed during a redirect so a stale word is never handed off.
    assign out_valid = (fifo_count != 2'd0) & ~redirect_valid;
    assign pop       = out_valid & out_ready;

    // Space check counts the word already in flight, so returning data always fits.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = redirect_valid | (occupancy < 3'd2);

    // The returning word belongs to the old stream when a redirect is active.
    assign push      = inflight & ~redirect_valid;
    assign push_dat  = {inflight_pc, mem_data};

    // PC advance and single in-flight read tracking.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (issue) begin
            inflight    <= 1'b1;
            inflight_pc <= issue_pc;
            pc          <= issue_pc + pc_t'(DATA_BYTES);
        end else begin
            inflight    <= 1'b0;
        end
    end

    fetch_fifo u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (redirect_valid),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count)
    );

    assign out_pc   = head.pc;
    assign out_insn = head.insn;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed cycles plus an output scoreboard.
// Latency: memory model returns data the cycle after the address edge.
// Backpressure: out_ready driven per directed vector.
module tb_fetch_ctrl;

    logic        clk;
    logic        resetn;
    logic [8:0]  mem_addr;
    logic [31:0] mem_data;
    logic        redirect_valid;
    logic [8:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_pc;
    logic [31:0] out_insn;

    int checks   = 0;
    int failures = 0;

    logic [8:0]  exp_pc_q[$];
    logic [31:0] exp_insn_q[$];
    logic [7:0]  mem [0:511];

    fetch_ctrl u_dut (
        .clk            (clk),
        .resetn         (resetn),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_insn       (out_insn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed memory with mem[i] = i, little-endian word read, registered.
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = i[7:0];
        mem_data = '0;
    end

    always @(posedge clk) begin
        mem_data <= {mem[mem_addr + 9'd3], mem[mem_addr + 9'd2],
                     mem[mem_addr + 9'd1], mem[mem_addr]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic expect_out(input logic [8:0] pc, input logic [31:0] insn);
        exp_pc_q.push_back(pc);
        exp_insn_q.push_back(insn);
    endtask

    // Advance to just after the next rising edge; inputs are then driven.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted output must match the next expected entry.
    always @(negedge clk) begin
        if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_pc_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output pc=0x%03h insn=0x%08h none expected", out_pc, out_insn);
            end else begin
                chk("sb_out_pc", {23'd0, out_pc}, {23'd0, exp_pc_q.pop_front()});
                chk("sb_out_insn", out_insn, exp_insn_q.pop_front());
            end
        end
    end

    initial begin
        resetn         = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pc", {23'd0, out_pc}, 32'd0);
        chk("rst_out_insn", out_insn, 32'd0);

        // cycle 0: first fetch after reset
        resetn = 1'b1;
        expect_out(9'h000, 32'h03020100);
        expect_out(9'h004, 32'h07060504);
        expect_out(9'h008, 32'h0B0A0908);
        expect_out(9'h00C, 32'h0F0E0D0C);
        expect_out(9'h010, 32'h13121110);
        #1;
        chk("c0_mem_addr", {23'd0, mem_addr}, 32'h000);
        chk("c0_out_valid", {31'd0, out_valid}, 32'd0);
        cyc(); #2;
        chk("c1_out_valid", {31'd0, out_valid}, 32'd0);
        chk("c1_mem_addr", {23'd0, mem_addr}, 32'h004);
        cyc(); #2;
        chk("c2_out_valid", {31'd0, out_valid}, 32'd1);
        chk("c2_out_pc", {23'd0, out_pc}, 32'h000);
        cyc(); #2;
        chk("c3_out_pc", {23'd0, out_pc}, 32'h004);

        // cycles 4..8: stall with 0x008 at the head
        for (int k = 0; k < 5; k++) begin
            cyc();
            out_ready = 1'b0;
            #2;
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_out_pc", {23'd0, out_pc}, 32'h008);
            chk("stall_out_insn", out_insn, 32'h0B0A0908);
            chk("stall_mem_addr", {23'd0, mem_addr}, 32'h010);
            if (k == 2) chk("stall_count", {30'd0, u_dut.fifo_count}, 32'd2);
        end

        // cycles 9..11: release, back-to-back with no gap
        cyc(); out_ready = 1'b1; #2;
        chk("rel0_out_pc", {23'd0, out_pc}, 32'h008);
        cyc(); #2;
        chk("rel1_out_valid", {31'd0, out_valid}, 32'd1);
        chk("rel1_out_pc", {23'd0, out_pc}, 32'h00C);
        cyc(); #2;
        chk("rel2_out_valid", {31'd0, out_valid}, 32'd1);
        chk("rel2_out_pc", {23'd0, out_pc}, 32'h010);

        // cycles 12..13: short stall to fill the FIFO, 0x014 never accepted
        cyc(); out_ready = 1'b0;
        cyc();

        // cycle 14: redirect to 0x100 with a full FIFO
        cyc();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 9'h100;
        #2;
        chk("redir_count", {30'd0, u_dut.fifo_count}, 32'd2);
        chk("redir_out_valid", {31'd0, out_valid}, 32'd0);
        chk("redir_mem_addr", {23'd0, mem_addr}, 32'h100);
        expect_out(9'h100, 32'h03020100);
        expect_out(9'h104, 32'h07060504);
        cyc(); redirect_valid = 1'b0; #2;
        chk("redir1_out_valid", {31'd0, out_valid}, 32'd0);
        cyc(); #2;
        chk("redir2_out_valid", {31'd0, out_valid}, 32'd1);
        chk("redir2_out_pc", {23'd0, out_pc}, 32'h100);
        cyc();

        // back-to-back redirects: 0x040 then misaligned 0x006, last one wins
        cyc(); redirect_valid = 1'b1; redirect_pc = 9'h040;
        cyc(); redirect_pc = 9'h006; #2;
        chk("b2b_out_valid", {31'd0, out_valid}, 32'd0);
        expect_out(9'h006, 32'h09080706);
        expect_out(9'h00A, 32'h0D0C0B0A);
        cyc(); redirect_valid = 1'b0; #2;
        chk("b2b1_out_valid", {31'd0, out_valid}, 32'd0);
        cyc(); #2;
        chk("mis_out_pc", {23'd0, out_pc}, 32'h006);
        chk("mis_out_insn", out_insn, 32'h09080706);
        cyc();

        // wrap-around from the top of the address space
        cyc(); redirect_valid = 1'b1; redirect_pc = 9'h1F8;
        expect_out(9'h1F8, 32'hFBFAF9F8);
        expect_out(9'h1FC, 32'hFFFEFDFC);
        expect_out(9'h000, 32'h03020100);
        expect_out(9'h004, 32'h07060504);
        cyc(); redirect_valid = 1'b0;
        cyc(); #2;
        chk("wrap_out_pc0", {23'd0, out_pc}, 32'h1F8);
        cyc(); #2;
        chk("wrap_out_insn1", out_insn, 32'hFFFEFDFC);
        cyc(); #2;
        chk("wrap_out_pc2", {23'd0, out_pc}, 32'h000);
        cyc();

        // stall to a full FIFO, then reset
        cyc(); out_ready = 1'b0;
        cyc(); #2;
        chk("pre_rst_count", {30'd0, u_dut.fifo_count}, 32'd2);
        chk("pre_rst_out_pc", {23'd0, out_pc}, 32'h008);
        cyc(); resetn = 1'b0;
        cyc();
        resetn    = 1'b1;
        out_ready = 1'b1;
        #2;
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_out_pc", {23'd0, out_pc}, 32'h000);
        chk("post_rst_out_insn", out_insn, 32'h0);
        chk("post_rst_mem_addr", {23'd0, mem_addr}, 32'h000);
        expect_out(9'h000, 32'h03020100);
        expect_out(9'h004, 32'h07060504);
        cyc(); #2;
        chk("post_rst1_out_valid", {31'd0, out_valid}, 32'd0);
        cyc(); #2;
        chk("post_rst2_out_pc", {23'd0, out_pc}, 32'h000);
        cyc();
        cyc(); out_ready = 1'b0;
        cyc();
        cyc(); #2;

        chk("sb_left_over", exp_pc_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
